// File: rtl/mem_dma_if.sv
// Control and memory-port bundle between mem_dma and its requester/memory.
interface mem_dma_if;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        verify_error;
  logic        mem_write_enable;
  logic [7:0]  write_address;
  logic [31:0] write_data;
  logic [7:0]  read_address1;
  logic [7:0]  read_address2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  modport slave (
    input  start, src_addr, dst_addr, length, read_data1, read_data2,
    output busy, done, verify_error, mem_write_enable,
           write_address, write_data, read_address1, read_address2
  );

  modport master (
    output start, src_addr, dst_addr, length, read_data1, read_data2,
    input  busy, done, verify_error, mem_write_enable,
           write_address, write_data, read_address1, read_address2
  );
endinterface

// File: rtl/mem_dma.sv
// Word-copy DMA: one word per cycle from src to dst, pointers wrap mod 256.
// Readback verification is built only when MEM_DMA_VERIFY_EN is defined.
module mem_dma (
  input  logic      clk,
  input  logic      rst,
  mem_dma_if.slave  bus
);

`ifdef MEM_DMA_VERIFY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, COPY = 2'd1, DONE = 2'd2, VERIFY = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, COPY = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] src_ptr_q, src_ptr_d;
  logic [7:0] dst_ptr_q, dst_ptr_d;
  logic [7:0] remaining_q, remaining_d;
  logic       start_acc;
  logic       in_copy;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign in_copy   = (state_q == COPY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_ptr_q   <= 8'd0;
      dst_ptr_q   <= 8'd0;
      remaining_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d     = COPY;
            src_ptr_d   = bus.src_addr;
            dst_ptr_d   = bus.dst_addr;
            remaining_d = bus.length;
          end
        end
      end
      COPY: begin
        src_ptr_d   = src_ptr_q + 8'd1;
        dst_ptr_d   = dst_ptr_q + 8'd1;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) begin
`ifdef MEM_DMA_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MEM_DMA_VERIFY_EN
      VERIFY:  state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe is gated by rst directly so a mid-copy reset stops writes that same cycle.
  always_comb begin
    bus.done             = (state_q == DONE);
`ifdef MEM_DMA_VERIFY_EN
    bus.busy             = in_copy || (state_q == VERIFY);
`else
    bus.busy             = in_copy;
`endif
    bus.mem_write_enable = in_copy && !rst;
    bus.write_address    = in_copy ? dst_ptr_q : 8'd0;
    bus.write_data       = in_copy ? bus.read_data1 : 32'd0;
    bus.read_address1    = in_copy ? src_ptr_q : 8'd0;
  end

`ifdef MEM_DMA_VERIFY_EN
  logic        prev_vld_q, prev_vld_d;
  logic [7:0]  prev_addr_q, prev_addr_d;
  logic [31:0] prev_data_q, prev_data_d;
  logic        verify_error_q, verify_error_d;
  logic        chk_en;

  // prev_vld_q marks that the previous cycle wrote a word, so readback is meaningful now.
  assign chk_en = prev_vld_q && (in_copy || (state_q == VERIFY));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_q     <= 1'b0;
      prev_addr_q    <= 8'd0;
      prev_data_q    <= 32'd0;
      verify_error_q <= 1'b0;
    end else begin
      prev_vld_q     <= prev_vld_d;
      prev_addr_q    <= prev_addr_d;
      prev_data_q    <= prev_data_d;
      verify_error_q <= verify_error_d;
    end
  end

  always_comb begin
    prev_vld_d     = in_copy;
    prev_addr_d    = dst_ptr_q;
    prev_data_d    = bus.read_data1;
    verify_error_d = verify_error_q;
    if (start_acc) begin
      verify_error_d = 1'b0;
    end else if (chk_en && (bus.read_data2 != prev_data_q)) begin
      verify_error_d = 1'b1;
    end
  end

  always_comb begin
    bus.read_address2 = chk_en ? prev_addr_q : 8'd0;
    bus.verify_error  = verify_error_q;
  end
`else
  always_comb begin
    bus.read_address2 = 8'd0;
    bus.verify_error  = 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural 256x32 memory and write monitor.
module tb_mem_dma;
  logic clk;
  logic rst;
  mem_dma_if ifc ();

  mem_dma dut (.clk(clk), .rst(rst), .bus(ifc));

`ifdef MEM_DMA_VERIFY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] WA = 32'hA5A5_0001;
  localparam logic [31:0] WB = 32'h1234_5678;
  localparam logic [31:0] WC = 32'hDEAD_BEEF;
  localparam logic [31:0] WD = 32'h0F0F_F0F0;

  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic        corrupt_en;
  logic [7:0]  corrupt_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  rd_addr_q[$];
  int          wr_cyc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ifc.mem_write_enable) mem[ifc.write_address] <= ifc.write_data;
  end

  assign ifc.read_data1 = mem[ifc.read_address1];
  assign ifc.read_data2 = mem[ifc.read_address2] ^
                          ((corrupt_en && ifc.read_address2 == corrupt_addr) ? 32'hFFFF_0000 : 32'h0);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ifc.mem_write_enable) begin
      wr_addr_q.push_back(ifc.write_address);
      wr_data_q.push_back(ifc.write_data);
      rd_addr_q.push_back(ifc.read_address1);
      wr_cyc_q.push_back(cyc);
    end
    if (ifc.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (ifc.busy) busy_cnt = busy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Leaves the bench on the negedge of the first cycle after acceptance, inputs scrambled.
  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    @(negedge clk);
    ifc.start = 1'b1; ifc.src_addr = s; ifc.dst_addr = d; ifc.length = n;
    @(negedge clk);
    ifc.start = 1'b0; ifc.src_addr = 8'h5A; ifc.dst_addr = 8'hA5; ifc.length = 8'hFF;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ifc.done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
    total++; if (ifc.verify_error !== 1'b0) begin bad++; $display("FAIL reset_verr got=%b exp=0", ifc.verify_error); end
    total++; if (ifc.mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", ifc.mem_write_enable); end
    total++; if (ifc.write_address !== 8'h00 || ifc.read_address1 !== 8'h00 || ifc.read_address2 !== 8'h00)
      begin bad++; $display("FAIL reset_addr got=%h/%h/%h exp=00/00/00", ifc.write_address, ifc.read_address1, ifc.read_address2); end
    total++; if (ifc.write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", ifc.write_data); end
  endtask

  task automatic test_basic;
    logic [31:0] exp_d [4];
    bit found;
    exp_d[0] = WA; exp_d[1] = WB; exp_d[2] = WC; exp_d[3] = WD;
    for (int i = 0; i < 4; i++) preload(8'h10 + 8'(i), exp_d[i]);
    clear_logs();
    kick(8'h10, 8'h80, 8'd4);
    total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", ifc.busy); end
    total++; if (ifc.mem_write_enable !== 1'b1 || ifc.write_address !== 8'h80 || ifc.write_data !== WA)
      begin bad++; $display("FAIL basic_first_wr got=%b/%h/%h exp=1/80/%h", ifc.mem_write_enable, ifc.write_address, ifc.write_data, WA); end
    tick(1);
`ifdef MEM_DMA_VERIFY_EN
    total++; if (ifc.read_address2 !== 8'h80) begin bad++; $display("FAIL basic_ra2 got=%h exp=80", ifc.read_address2); end
`else
    total++; if (ifc.read_address2 !== 8'h00) begin bad++; $display("FAIL basic_ra2 got=%h exp=00", ifc.read_address2); end
`endif
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL basic_done_timeout got=none exp=done"); end
    total++; if (ifc.busy !== 1'b0 || ifc.verify_error !== 1'b0)
      begin bad++; $display("FAIL basic_done_state got=busy%b verr%b exp=busy0 verr0", ifc.busy, ifc.verify_error); end
    tick(3);
    total++; if (wr_addr_q.size() !== 4) begin bad++; $display("FAIL basic_wr_count got=%0d exp=4", wr_addr_q.size()); end
    if (wr_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (wr_addr_q[i] !== 8'h80 + 8'(i) || wr_data_q[i] !== exp_d[i])
          begin bad++; $display("FAIL basic_wr%0d got=%h:%h exp=%h:%h", i, wr_addr_q[i], wr_data_q[i], 8'h80 + 8'(i), exp_d[i]); end
        total++; if (mem[8'h80 + 8'(i)] !== exp_d[i])
          begin bad++; $display("FAIL basic_mem%0d got=%h exp=%h", i, mem[8'h80 + 8'(i)], exp_d[i]); end
      end
      total++; if (wr_cyc_q[3] - wr_cyc_q[0] !== 3) begin bad++; $display("FAIL basic_consec got=%0d exp=3", wr_cyc_q[3] - wr_cyc_q[0]); end
      total++; if (done_cyc - wr_cyc_q[3] !== LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", done_cyc - wr_cyc_q[3], LAT); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (ifc.write_address !== 8'h00 || ifc.write_data !== 32'h0 || ifc.read_address1 !== 8'h00)
      begin bad++; $display("FAIL basic_idle_zero got=%h/%h/%h exp=0", ifc.write_address, ifc.write_data, ifc.read_address1); end
  endtask

  task automatic test_zero_len;
    clear_logs();
    kick(8'h40, 8'h60, 8'd0);
    total++; if (ifc.done !== 1'b1 || ifc.busy !== 1'b0)
      begin bad++; $display("FAIL zlen_done got=done%b busy%b exp=done1 busy0", ifc.done, ifc.busy); end
    tick(4);
    total++; if (wr_addr_q.size() !== 0) begin bad++; $display("FAIL zlen_writes got=%0d exp=0", wr_addr_q.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zlen_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL zlen_busy_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_wrap;
    logic [7:0]  exp_r [3];
    logic [31:0] exp_d [3];
    bit found;
    exp_r[0] = 8'hFE; exp_r[1] = 8'hFF; exp_r[2] = 8'h00;
    exp_d[0] = 32'h0000_00FE; exp_d[1] = 32'h0000_00FF; exp_d[2] = 32'h1000_0000;
    for (int i = 0; i < 3; i++) preload(exp_r[i], exp_d[i]);
    clear_logs();
    kick(8'hFE, 8'h01, 8'd3);
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL wrap_done_timeout got=none exp=done"); end
    tick(2);
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("FAIL wrap_wr_count got=%0d exp=3", wr_addr_q.size()); end
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (rd_addr_q[i] !== exp_r[i] || wr_addr_q[i] !== 8'h01 + 8'(i))
          begin bad++; $display("FAIL wrap_addr%0d got=rd%h wr%h exp=rd%h wr%h", i, rd_addr_q[i], wr_addr_q[i], exp_r[i], 8'h01 + 8'(i)); end
        total++; if (mem[8'h01 + 8'(i)] !== exp_d[i])
          begin bad++; $display("FAIL wrap_mem%0d got=%h exp=%h", i, mem[8'h01 + 8'(i)], exp_d[i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) preload(8'h20 + 8'(i), 32'hB000_0000 + i);
    preload(8'h92, 32'hCAFE_F00D);
    clear_logs();
    kick(8'h20, 8'h90, 8'd8);
    tick(2);
    rst = 1'b1;
    #1;
    total++; if (ifc.mem_write_enable !== 1'b0) begin bad++; $display("FAIL rmid_we_gate got=%b exp=0", ifc.mem_write_enable); end
    tick(1);
    rst = 1'b0;
    #1;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", ifc.busy); end
    tick(5);
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL rmid_wr_count got=%0d exp=2", wr_addr_q.size()); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rmid_done_cnt got=%0d exp=0", done_cnt); end
    total++; if (mem[8'h90] !== 32'hB000_0000 || mem[8'h91] !== 32'hB000_0001)
      begin bad++; $display("FAIL rmid_kept got=%h/%h exp=b0000000/b0000001", mem[8'h90], mem[8'h91]); end
    total++; if (mem[8'h92] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rmid_untouched got=%h exp=cafef00d", mem[8'h92]); end
  endtask

  task automatic test_restart_busy;
    bit found;
    clear_logs();
    kick(8'h10, 8'hA0, 8'd4);
    @(negedge clk);
    ifc.start = 1'b1; ifc.src_addr = 8'h20; ifc.dst_addr = 8'hC0; ifc.length = 8'd2;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL rbusy_done_timeout got=none exp=done"); end
    tick(8);
    total++; if (wr_addr_q.size() !== 4) begin bad++; $display("FAIL rbusy_wr_count got=%0d exp=4", wr_addr_q.size()); end
    if (wr_addr_q.size() == 4) begin
      total++; if (wr_addr_q[0] !== 8'hA0 || wr_addr_q[3] !== 8'hA3)
        begin bad++; $display("FAIL rbusy_addrs got=%h..%h exp=a0..a3", wr_addr_q[0], wr_addr_q[3]); end
    end
    total++; if (mem[8'hA1] !== WB) begin bad++; $display("FAIL rbusy_mem got=%h exp=%h", mem[8'hA1], WB); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rbusy_done_cnt got=%0d exp=1", done_cnt); end
  endtask

`ifdef MEM_DMA_VERIFY_EN
  task automatic test_verify;
    bit found;
    preload(8'h30, WA); preload(8'h31, WB); preload(8'h32, WC); preload(8'h33, WD);
    corrupt_addr = 8'h51;
    corrupt_en   = 1'b1;
    kick(8'h30, 8'h50, 8'd4);
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL verify_done_timeout got=none exp=done"); end
    total++; if (ifc.verify_error !== 1'b1) begin bad++; $display("FAIL verify_err_at_done got=%b exp=1", ifc.verify_error); end
    corrupt_en = 1'b0;
    tick(2);
    total++; if (ifc.verify_error !== 1'b1) begin bad++; $display("FAIL verify_sticky got=%b exp=1", ifc.verify_error); end
    kick(8'h30, 8'h60, 8'd2);
    total++; if (ifc.verify_error !== 1'b0) begin bad++; $display("FAIL verify_clear got=%b exp=0", ifc.verify_error); end
    wait_done(found);
    total++; if (ifc.verify_error !== 1'b0) begin bad++; $display("FAIL verify_clean_run got=%b exp=0", ifc.verify_error); end
    tick(2);
  endtask
`endif

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.src_addr = 8'h00; ifc.dst_addr = 8'h00; ifc.length = 8'h00;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 32'h0;
    corrupt_en = 1'b0; corrupt_addr = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_restart_busy();
`ifdef MEM_DMA_VERIFY_EN
    test_verify();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-004 Port start, input, 1 bit: request a copy; sampled only in IDLE.
REQ-005 Port src_addr, input, 8 bits: first source word address.
REQ-006 Port dst_addr, input, 8 bits: first destination word address.
REQ-007 Port length, input, 8 bits: number of words to copy, 0..255.
REQ-008 Port busy, output, 1 bit: high while in COPY or VERIFY.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port verify_error, output, 1 bit: sticky readback-mismatch flag.
REQ-011 Port mem_write_enable, output, 1 bit: drives the memory write strobe.
REQ-012 Port write_address, output, 8 bits: memory write address.
REQ-013 Port write_data, output, 32 bits: memory write data.
REQ-014 Port read_address1, output, 8 bits: source read address.
REQ-015 Port read_address2, output, 8 bits: readback (verify) address.
REQ-016 Port read_data1, input, 32 bits: combinational read data for read_address1, same cycle.
REQ-017 Port read_data2, input, 32 bits: combinational read data for read_address2, same cycle.

Function
REQ-018 The FSM SHALL have states IDLE, COPY, VERIFY and DONE.
REQ-019 IDLE: busy=0 and mem_write_enable=0.
  - start=1 with length!=0: latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=length; next state COPY.
  - start=1 with length=0: next state DONE; no memory write occurs.
REQ-020 COPY, every cycle:
  - read_address1=src_ptr, write_address=dst_ptr, write_data=read_data1, mem_write_enable=1 (combinational).
  - src_ptr and dst_ptr increment, remaining decrements.
REQ-021 Throughput SHALL be one word per cycle: a copy of N words SHALL assert mem_write_enable for exactly N consecutive cycles.
REQ-022 On the COPY cycle with remaining=1, next state SHALL be VERIFY when MEM_DMA_VERIFY_EN is defined, otherwise DONE.
REQ-023 VERIFY SHALL last one cycle with mem_write_enable=0, then go to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-025 Pointers SHALL wrap modulo 256 (255 -> 0) independently.
REQ-026 The copy SHALL proceed in ascending address order one word per cycle; overlapping regions yield that sequential result and are not corrected.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 Latched src_addr, dst_addr and length SHALL be unaffected by input changes after acceptance.
REQ-029 When not in COPY, mem_write_enable=0 and write_address, write_data and read_address1 SHALL be 0.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, clear pointers and remaining, and set busy=0, done=0 and verify_error=0.
REQ-031 mem_write_enable SHALL be 0 combinationally in any cycle where rst=1, so that reset mid-COPY aborts with no further writes; words already written stay written.

Configuration
REQ-032 With MEM_DMA_VERIFY_EN defined, readback checking SHALL operate as follows:
  - In each COPY cycle after the first and in VERIFY, read_address2 = the previous cycle's write_address.
  - read_data2 is compared with the registered previous write_data.
  - Any mismatch sets verify_error, which holds until the next accepted start or rst.
REQ-033 Without MEM_DMA_VERIFY_EN:
  - The VERIFY state and the comparison logic SHALL be absent.
  - read_address2=0 and verify_error=0 at all times.
  - Completion latency after the last write is one cycle shorter.

Verification
REQ-034 Preload mem[0x10..0x13]=A,B,C,D; start src=0x10, dst=0x80, len=4 -> writes to 0x80..0x83 on 4 consecutive cycles, mem[0x80..0x83]=A..D, one done pulse, verify_error=0.
REQ-035 start with len=0 -> no mem_write_enable, done pulses on the next cycle, busy stays 0.
REQ-036 src=0xFE, dst=0x01, len=3 -> reads 0xFE, 0xFF, 0x00 and writes 0x01, 0x02, 0x03.
REQ-037 rst asserted on the 3rd COPY cycle of a len=8 copy -> exactly 2 words written, then IDLE, busy=0, done never pulses.
REQ-038 start re-asserted while busy -> ignored; only the first transfer completes, with a single done pulse.
REQ-039 With MEM_DMA_VERIFY_EN, force read_data2 to differ on the 2nd word -> verify_error=1 through DONE; a new start clears it.
